// File: rtl/mix_field_unit.sv
// mix_field_unit: byte-serial MIX field-spec STORE / LOAD / LOADN on a sign + NBYTES*BYTE_W word (optional macro MIX_FIELD_FASTPATH_EN).
// Latency: stop pulses 1+N cycles after the start edge (N = bytes in the field); 1 cycle for invalid or sign-only requests.
// Backpressure: none; start is honoured only in IDLE and is ignored while busy. Full-word fields finish in 1 cycle with the macro defined.
module mix_field_unit #(
    parameter int BYTE_W = 6,
    parameter int NBYTES = 5,
    parameter int WORD_W = 1 + NBYTES * BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [5:0]        field,
    input  logic [WORD_W-1:0] data,
    input  logic [WORD_W-1:0] in,
    output logic [WORD_W-1:0] out,
    output logic              stop,
    output logic              err,
    output logic              busy
);
    localparam int BODY_W = NBYTES * BYTE_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] M_STORE = 2'b00;
    localparam logic [1:0] M_LOADN = 2'b10;
    localparam logic [1:0] M_RSVD  = 2'b11;

    logic [1:0]        state;
    logic [BODY_W-1:0] data_q;
    logic [BODY_W-1:0] in_q;
    logic              is_store_q;
    logic              bad_q;
    logic [2:0]        lb_q;
    logic [2:0]        dst_q;
    logic [2:0]        src_q;
    logic [WORD_W-1:0] work_q;

    logic [2:0]        fl;
    logic [2:0]        fr;
    logic [2:0]        lb;
    logic              req_bad;
    logic              init_sign;
    logic [WORD_W-1:0] init_word;
    logic [2:0]        wr_idx;
    logic [BYTE_W-1:0] wr_byte;
`ifdef MIX_FIELD_FASTPATH_EN
    logic              full_word;
    logic [WORD_W-1:0] fast_word;
`endif

    // Byte k (1 = most significant) of a sign-less word body; indices outside 1..NBYTES read as zero.
    function automatic logic [BYTE_W-1:0] get_byte(input logic [BODY_W-1:0] w, input logic [2:0] k);
        logic [BYTE_W-1:0] b;
        b = '0;
        for (int i = 1; i <= NBYTES; i++) begin
            if (k == 3'(i)) begin
                b = w[(NBYTES-i)*BYTE_W +: BYTE_W];
            end
        end
        return b;
    endfunction

    // Decode the field spec and build the starting working word for an accepted request.
    always_comb begin
        fl      = field[5:3];
        fr      = field[2:0];
        lb      = (fl == 3'd0) ? 3'd1 : fl;
        req_bad = (fl > fr) || (fr > 3'(NBYTES)) || (mode == M_RSVD);
        if (mode == M_STORE) begin
            init_sign = (fl == 3'd0) ? in[WORD_W-1] : data[WORD_W-1];
            init_word = {init_sign, data[BODY_W-1:0]};
        end else begin
            init_sign = (fl == 3'd0) ? data[WORD_W-1] : 1'b0;
            if (mode == M_LOADN) begin
                init_sign = ~init_sign;
            end
            init_word = {init_sign, {BODY_W{1'b0}}};
        end
`ifdef MIX_FIELD_FASTPATH_EN
        full_word = (fl == 3'd0) && (fr == 3'(NBYTES));
        if (mode == M_STORE) begin
            fast_word = in;
        end else if (mode == M_LOADN) begin
            fast_word = {~data[WORD_W-1], data[BODY_W-1:0]};
        end else begin
            fast_word = data;
        end
`endif
    end

    // STORE moves register byte src into field byte dst; LOAD moves field byte dst into result byte src.
    always_comb begin
        wr_idx  = is_store_q ? dst_q : src_q;
        wr_byte = is_store_q ? get_byte(in_q, src_q) : get_byte(data_q, dst_q);
    end

    assign busy = (state != S_IDLE);

    // Sequencer: latch operands on start, walk the field one byte per cycle, publish the result with a stop pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            data_q     <= '0;
            in_q       <= '0;
            is_store_q <= 1'b0;
            bad_q      <= 1'b0;
            lb_q       <= '0;
            dst_q      <= '0;
            src_q      <= '0;
            work_q     <= '0;
            out        <= '0;
            stop       <= 1'b0;
            err        <= 1'b0;
        end else begin
            stop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data_q     <= data[BODY_W-1:0];
                        in_q       <= in[BODY_W-1:0];
                        is_store_q <= (mode == M_STORE);
                        bad_q      <= req_bad;
                        lb_q       <= lb;
                        dst_q      <= fr;
                        src_q      <= 3'(NBYTES);
                        err        <= 1'b0;
                        if (req_bad) begin
                            work_q <= data;
                            state  <= S_DONE;
                        end
`ifdef MIX_FIELD_FASTPATH_EN
                        else if (full_word) begin
                            work_q <= fast_word;
                            state  <= S_DONE;
                        end
`endif
                        else begin
                            work_q <= init_word;
                            // Field 0:0 touches only the sign, which is already in place.
                            state  <= (fr == 3'd0) ? S_DONE : S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    for (int i = 1; i <= NBYTES; i++) begin
                        if (wr_idx == 3'(i)) begin
                            work_q[(NBYTES-i)*BYTE_W +: BYTE_W] <= wr_byte;
                        end
                    end
                    dst_q <= dst_q - 3'd1;
                    src_q <= src_q - 3'd1;
                    if (dst_q == lb_q) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    out   <= work_q;
                    stop  <= 1'b1;
                    err   <= bad_q;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
